// File: rtl/seg7_byte_rx.sv
// Receive side of the 7-segment loopback: decodes active-low segment patterns
// back to hex nibbles and pairs them (low digit first) into bytes on a valid/ready port.
module seg7_byte_rx #(
    parameter int ERR_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             lo_pending,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {EXP_LO, EXP_HI, HOLD} state_e;

    state_e           state_q, state_d;
    logic [3:0]       lo_q, lo_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic       legal;
    logic [3:0] nibble;
    logic       accept;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        unique case (seg_in)
            7'b1000000: nibble = 4'h0;
            7'b1111001: nibble = 4'h1;
            7'b0100100: nibble = 4'h2;
            7'b0110000: nibble = 4'h3;
            7'b0011001: nibble = 4'h4;
            7'b0010010: nibble = 4'h5;
            7'b0000010: nibble = 4'h6;
            7'b1111000: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0010000: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b0000011: nibble = 4'hB;
            7'b1000110: nibble = 4'hC;
            7'b0100001: nibble = 4'hD;
            7'b0000110: nibble = 4'hE;
            7'b0001110: nibble = 4'hF;
            default:    legal  = 1'b0;
        endcase
    end

    assign accept = seg_valid && seg_ready;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        byte_d      = byte_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        seg_ready   = 1'b0;
        byte_valid  = 1'b0;
        lo_pending  = 1'b0;

        unique case (state_q)
            EXP_LO: begin
                seg_ready = 1'b1;
                if (accept && legal) begin
                    lo_d    = nibble;
                    state_d = EXP_HI;
                end
            end
            EXP_HI: begin
                seg_ready  = 1'b1;
                lo_pending = 1'b1;
                if (accept) begin
                    if (legal) begin
                        byte_d  = {nibble, lo_q};
                        state_d = HOLD;
                    end else begin
                        state_d = EXP_LO;
                    end
                end
            end
            HOLD: begin
                byte_valid = 1'b1;
                if (byte_ready) state_d = EXP_LO;
            end
            default: state_d = EXP_LO;
        endcase

        // Error path is independent of state; accept already implies seg_ready.
        if (accept && !legal) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= EXP_LO;
            lo_q        <= 4'h0;
            byte_q      <= 8'h00;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            byte_q      <= byte_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign byte_out  = byte_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg7_byte_rx.sv
// Scoreboard bench for seg7_byte_rx: expected bytes are queued when the high
// nibble is driven and compared when the DUT presents byte_valid.
module tb_seg7_byte_rx;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg_in = 7'h7F;
    logic       seg_valid = 1'b0;
    logic       seg_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       lo_pending;
    logic       err_pulse;
    logic [7:0] err_cnt;

    logic [6:0] s_seg_in = 7'h7F;
    logic       s_seg_valid = 1'b0;
    logic       s_seg_ready;
    logic [7:0] s_byte_out;
    logic       s_byte_valid;
    logic       s_byte_ready = 1'b1;
    logic       s_lo_pending;
    logic       s_err_pulse;
    logic [1:0] s_err_cnt;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [6:0] bad [5] = '{7'h7F, 7'h01, 7'h2A, 7'h55, 7'h7E};

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_byte_rx #(.ERR_W(8)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(seg_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .lo_pending(lo_pending), .err_pulse(err_pulse),
        .err_cnt(err_cnt)
    );

    seg7_byte_rx #(.ERR_W(2)) dut_sat (
        .CLOCK_50(CLOCK_50), .reset(reset), .seg_in(s_seg_in), .seg_valid(s_seg_valid),
        .seg_ready(s_seg_ready), .byte_out(s_byte_out), .byte_valid(s_byte_valid),
        .byte_ready(s_byte_ready), .lo_pending(s_lo_pending), .err_pulse(s_err_pulse),
        .err_cnt(s_err_cnt)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Drive one pattern for a single cycle; sampling happens at the following negedge.
    task automatic send(input logic [6:0] p);
        seg_in = p;
        seg_valid = 1'b1;
        @(negedge CLOCK_50);
        seg_valid = 1'b0;
    endtask

    task automatic send_pair(input int lo, input int hi);
        send(glyph[lo]);
        send(glyph[hi]);
        exp_q.push_back({hi[3:0], lo[3:0]});
    endtask

    task automatic take_byte(input string name);
        int k = 0;
        logic [7:0] e;
        while (!byte_valid && k < 20) begin
            @(negedge CLOCK_50);
            k++;
        end
        cmp({name, "_valid"}, byte_valid, 1'b1);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_queue: got byte 0x%0h expected none", name, byte_out);
        end else begin
            e = exp_q.pop_front();
            cmp({name, "_byte"}, byte_out, e);
        end
        byte_ready = 1'b1;
        @(negedge CLOCK_50);
        byte_ready = 1'b0;
        cmp({name, "_valid_drop"}, byte_valid, 1'b0);
        cmp({name, "_ready_back"}, seg_ready, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        cmp("rst_seg_ready", seg_ready, 1'b1);
        cmp("rst_byte_valid", byte_valid, 1'b0);
        cmp("rst_lo_pending", lo_pending, 1'b0);
        cmp("rst_byte_out", byte_out, 8'h00);
        cmp("rst_err_cnt", err_cnt, 8'h00);
        cmp("rst_err_pulse", err_pulse, 1'b0);
    endtask

    task automatic test_legal_byte;
        send(glyph[2]);
        cmp("legal_lo_pending", lo_pending, 1'b1);
        send(glyph[4]);
        exp_q.push_back(8'h42);
        cmp("legal_seg_ready_hold", seg_ready, 1'b0);
        repeat (3) @(negedge CLOCK_50);
        cmp("legal_still_valid", byte_valid, 1'b1);
        cmp("legal_still_blocked", seg_ready, 1'b0);
        take_byte("legal");
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 8; i++) begin
            send_pair(2 * i, 2 * i + 1);
            take_byte("sweep");
        end
        cmp("sweep_err_cnt", err_cnt, 8'h00);
    endtask

    task automatic test_illegal_hi;
        send(glyph[1]);
        send(7'b1111111);
        cmp("ill_err_pulse", err_pulse, 1'b1);
        cmp("ill_err_cnt", err_cnt, 8'd1);
        cmp("ill_lo_pending", lo_pending, 1'b0);
        cmp("ill_no_byte", byte_valid, 1'b0);
        @(negedge CLOCK_50);
        cmp("ill_pulse_single", err_pulse, 1'b0);
        send_pair(8, 10);
        take_byte("ill_recover");
    endtask

    task automatic test_back_to_back_pressure;
        send_pair(12, 5);
        for (int i = 0; i < 10; i++) begin
            seg_in = (i % 2 == 0) ? bad[i % 5] : glyph[i];
            seg_valid = 1'b1;
            @(negedge CLOCK_50);
            cmp("bp_byte_out", byte_out, 8'h5C);
            cmp("bp_valid", byte_valid, 1'b1);
            cmp("bp_err_pulse", err_pulse, 1'b0);
            cmp("bp_err_cnt", err_cnt, 8'd1);
        end
        seg_valid = 1'b0;
        take_byte("bp");
    endtask

    task automatic test_saturation;
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            s_seg_in = bad[i];
            s_seg_valid = 1'b1;
            @(negedge CLOCK_50);
            if (s_err_pulse === 1'b1) pulses++;
            cmp("sat_err_cnt", s_err_cnt, (i < 3) ? i + 1 : 3);
        end
        s_seg_valid = 1'b0;
        @(negedge CLOCK_50);
        cmp("sat_pulse_count", pulses, 5);
        cmp("sat_pulse_idle", s_err_pulse, 1'b0);
        cmp("sat_hold", s_err_cnt, 2'd3);
    endtask

    task automatic test_reset_mid;
        send(glyph[1]);
        cmp("rmid_hi_pending", lo_pending, 1'b1);
        reset = 1'b1;
        seg_in = glyph[3];
        seg_valid = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        seg_valid = 1'b0;
        cmp("rmid_hi_valid", byte_valid, 1'b0);
        cmp("rmid_hi_lo_pending", lo_pending, 1'b0);
        cmp("rmid_hi_err_cnt", err_cnt, 8'd0);
        cmp("rmid_hi_seg_ready", seg_ready, 1'b1);
        send_pair(6, 7);
        take_byte("rmid_hi_fresh");

        send(glyph[3]);
        send(glyph[9]);
        cmp("rmid_hold_in", byte_valid, 1'b1);
        reset = 1'b1;
        byte_ready = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        byte_ready = 1'b0;
        cmp("rmid_hold_valid", byte_valid, 1'b0);
        cmp("rmid_hold_lo_pending", lo_pending, 1'b0);
        cmp("rmid_hold_err_cnt", err_cnt, 8'd0);
        cmp("rmid_hold_seg_ready", seg_ready, 1'b1);
        cmp("rmid_hold_byte_out", byte_out, 8'h00);
        send_pair(14, 1);
        take_byte("rmid_hold_fresh");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_legal_byte();
        test_sweep();
        test_illegal_hi();
        test_back_to_back_pressure();
        test_saturation();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
